// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator on a req/gnt + rvalid bus; accept->rsp is 3 cycles (aligned load) or 2 (aligned store).
// The pipeline stalls while req_ready=0 (every state but IDLE); `LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two word beats.
module lsu_mem_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam int unsigned   CW      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t        state;
  logic          st;
  logic [2:0]    f3;
  logic [1:0]    sh;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  logic [1:0]    off, sh_n;
  logic          is_h, is_w, legal, mis, bad;
  logic [3:0]    base, be0_n;
  logic [31:0]   rep, wd_n, ld_sh, ld_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic          two, beat;
  logic [3:0]    be1;
  logic [31:0]   lo_buf;
  logic [7:0]    be8;
  logic [63:0]   rot64, ld64;
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  // Request decode: sh is the byte shift used for both lane placement and load extraction.
  always_comb begin
    off  = req_addr[1:0];
    is_h = (req_funct3[1:0] == 2'b01);
    is_w = (req_funct3[1:0] == 2'b10);
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_store;
      default:                legal = 1'b0;
    endcase
    mis  = (is_h && off == 2'b11) || (is_w && off != 2'b00);
    sh_n = (is_h && !mis) ? {off[1], 1'b0} : off;
    base = is_w ? 4'b1111 : (is_h ? 4'b0011 : 4'b0001);
    rep  = is_w ? req_wdata : (is_h ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}});
`ifdef LSU_MISALIGN_SPLIT_EN
    bad   = !legal;
    be8   = {4'b0000, base} << sh_n;
    be0_n = be8[3:0];
    rot64 = {rep, rep} << {sh_n, 3'b000};
    wd_n  = rot64[63:32];
`else
    bad   = !legal || mis;
    be0_n = base << sh_n;
    wd_n  = rep;
`endif
  end

  // Load path: beat-1 word sits above beat-0 word so one shift reassembles little-endian bytes.
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    ld64  = beat ? {mem_rdata, lo_buf} : {32'h0, mem_rdata};
    ld_sh = 32'(ld64 >> {sh, 3'b000});
`else
    ld_sh = mem_rdata >> {sh, 3'b000};
`endif
    case (f3)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'h0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      st        <= 1'b0;
      f3        <= 3'h0;
      sh        <= 2'h0;
      cnt       <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      two       <= 1'b0;
      beat      <= 1'b0;
      be1       <= 4'h0;
      lo_buf    <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            st        <= req_store;
            f3        <= req_funct3;
            sh        <= sh_n;
            cnt       <= '0;
            mem_we    <= req_store;
            mem_be    <= be0_n;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wd_n;
`ifdef LSU_MISALIGN_SPLIT_EN
            two       <= (be8[7:4] != 4'h0);
            beat      <= 1'b0;
            be1       <= be8[7:4];
`endif
            if (bad) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            if (!st) begin
              state <= S_WAIT;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if (two && !beat) begin
              beat     <= 1'b1;
              mem_req  <= 1'b1;
              mem_be   <= be1;
              mem_addr <= mem_addr + ADDR_W'(4);
            end
`endif
            else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
            end
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            cnt <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (two && !beat) begin
              lo_buf   <= mem_rdata;
              beat     <= 1'b1;
              mem_req  <= 1'b1;
              mem_be   <= be1;
              mem_addr <= mem_addr + ADDR_W'(4);
              state    <= S_REQ;
            end else
`endif
            begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= ld_ext;
            end
          end else if (timeout_hit) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
